exc_pc_sequencer: RTL and testbench
===================================

Name: exc_pc_sequencer

Overview:
- Exception and PC-source sequencer for the multicycle CPU; it is the producer side of the PC-source multiplexer.
- On an exception it records EPC, fetches the handler vector byte from memory, and drives the mux select and PC write to load the handler address.
- On return-from-exception it drives the select that restores PC from EPC.
- While idle, the main control unit's PC select and write pass through unchanged.

Parameters:
- VEC_OPCODE, 32'd253, memory address holding the invalid-opcode handler byte
- VEC_OVF, 32'd254, memory address holding the overflow handler byte
- VEC_DIV0, 32'd255, memory address holding the divide-by-zero handler byte
- PC_ADJ, 32'd4, value subtracted from pc_in when EPC is captured
- ACK_TIMEOUT, 15, FETCH wait cycles before fault (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_in  in  32  current PC register value
- exc_opcode  in  1  invalid-opcode exception request (level, sampled in IDLE)
- exc_ovf  in  1  arithmetic overflow request
- exc_div0  in  1  divide-by-zero request
- rte  in  1  return-from-exception request
- ctrl_pc_sel  in  3  PC-source select from the main control unit
- ctrl_pc_write  in  1  PC write enable from the main control unit
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory read data valid
- mem_req  out  1  memory read request
- mem_addr  out  32  memory read address
- epc_out  out  32  EPC register; feeds mux input 000
- handler_addr  out  32  zero-extended handler address; feeds mux input 001
- mux_pc_sel  out  3  select to the PC-source mux
- pc_write  out  1  PC write enable
- exc_busy  out  1  stall request to the main control unit
- exc_cause  out  2  last cause: 00 none, 01 opcode, 10 overflow, 11 div0
- exc_fault  out  1  sticky memory-timeout fault (optional feature only)

Behaviour:
- Reset (async, while reset=0):
  - State IDLE; epc_out, handler_addr = 0; exc_cause = 00; exc_fault = 0.
  - mem_req = 0; mem_addr = 0; exc_busy = 0.
  - mux_pc_sel and pc_write follow the IDLE rules below.
- States: IDLE, FETCH, LOAD, RET (plus HALT with the optional feature).
- IDLE:
  - mux_pc_sel = ctrl_pc_sel; pc_write = ctrl_pc_write; exc_busy = 0; mem_req = 0.
  - At a clock edge with any exception input high:
    - epc_out <= pc_in - PC_ADJ (32-bit wrap; pc_in = 0 gives 32'hFFFFFFFC).
    - exc_cause <= highest-priority cause; priority is opcode > div0 > ovf.
    - Vector address latched; next state FETCH.
  - Else, at an edge with rte high: next state RET.
  - Exception and rte in the same cycle: exception wins, rte is dropped.
- FETCH:
  - mem_req = 1; mem_addr = latched vector; exc_busy = 1.
  - mux_pc_sel = ctrl_pc_sel; pc_write = 0.
  - At an edge with mem_ack = 1: handler_addr <= {24'b0, mem_rdata[7:0]}; next state LOAD.
  - Without mem_ack, stay in FETCH and hold mem_req and mem_addr stable.
- LOAD: mux_pc_sel = 3'b001; pc_write = 1; exc_busy = 1; mem_req = 0. Exactly one cycle, then IDLE.
- RET: mux_pc_sel = 3'b000; pc_write = 1; exc_busy = 1. Exactly one cycle, then IDLE. EPC is unchanged.
- Exception and rte inputs are ignored outside IDLE; there is no nesting and no queueing.
- Latency:
  - Exception sampled at edge E0, mem_ack present in the first FETCH cycle: handler is written into PC at edge E2.
  - rte sampled at edge E0: PC is restored at edge E1.
- mux_pc_sel, pc_write, mem_req and mem_addr are combinational from the state and control inputs; all other outputs are registered.
- Reset asserted mid-FETCH: mem_req drops immediately (asynchronously); no partial handler_addr update.

Optional Feature:
- Macro: EXC_ACK_TIMEOUT_EN.
- Defined:
  - A 4-bit counter clears on entry to FETCH and increments each FETCH cycle without mem_ack.
  - When the count reaches ACK_TIMEOUT: exc_fault <= 1 (sticky until reset), next state HALT.
  - HALT: exc_busy = 1, pc_write = 0, mem_req = 0; remains in HALT until reset.
- Undefined: FETCH waits indefinitely; exc_fault is tied to 0; HALT and the counter do not exist.

Test Plan:
- Reset, then IDLE with ctrl_pc_sel = 3'b010 and ctrl_pc_write = 1 -> mux_pc_sel = 010, pc_write = 1, exc_busy = 0, epc_out = 0.
- pc_in = 32'h0000_0040, exc_ovf pulse; ack after 2 cycles with mem_rdata = 32'hAABBCC7F -> mem_addr = 254; epc_out = 32'h3C; exc_cause = 10; LOAD cycle shows mux_pc_sel = 001, pc_write = 1, handler_addr = 32'h7F.
- exc_opcode, exc_ovf and exc_div0 all high in the same cycle -> exc_cause = 01, mem_addr = 253.
- After the exception above, rte -> one cycle with mux_pc_sel = 000, pc_write = 1; epc_out stays 32'h3C. A second exception asserted during LOAD is ignored.
- rte and exc_div0 high together in IDLE with pc_in = 0 -> FETCH at address 255, epc_out = 32'hFFFFFFFC, no RET cycle.
- With EXC_ACK_TIMEOUT_EN defined, mem_ack held low -> exc_fault = 1 after 15 FETCH cycles, exc_busy stays high, pc_write stays 0 until reset. Asserting reset mid-FETCH -> mem_req = 0 immediately.

Source files
------------

// File: rtl/exc_pc_sequencer.sv
// Exception / PC-source sequencer: captures EPC, fetches the handler vector byte, drives the PC mux.
// Optional memory-ack timeout with sticky fault and HALT state: define EXC_ACK_TIMEOUT_EN.
module exc_pc_sequencer #(
   parameter logic [31:0] VEC_OPCODE  = 32'd253,
   parameter logic [31:0] VEC_OVF     = 32'd254,
   parameter logic [31:0] VEC_DIV0    = 32'd255,
   parameter logic [31:0] PC_ADJ      = 32'd4,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic        rte,
   input  logic [2:0]  ctrl_pc_sel,
   input  logic        ctrl_pc_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] epc_out,
   output logic [31:0] handler_addr,
   output logic [2:0]  mux_pc_sel,
   output logic        pc_write,
   output logic        exc_busy,
   output logic [1:0]  exc_cause,
   output logic        exc_fault
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      RET
`ifdef EXC_ACK_TIMEOUT_EN
      , HALT
`endif
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_epc, r_handler, r_vec;
   logic [1:0]  r_cause;
   logic        r_busy;
   logic        w_any_exc;
   logic [1:0]  w_cause;
   logic [31:0] w_vec;
   logic        w_unused_rdata;

   assign w_any_exc      = exc_opcode | exc_ovf | exc_div0;
   assign w_unused_rdata = ^mem_rdata[31:8];

   // Priority: opcode > div0 > overflow
   always_comb begin
      if (exc_opcode) begin
         w_cause = 2'b01;
         w_vec   = VEC_OPCODE;
      end else if (exc_div0) begin
         w_cause = 2'b11;
         w_vec   = VEC_DIV0;
      end else begin
         w_cause = 2'b10;
         w_vec   = VEC_OVF;
      end
   end

`ifdef EXC_ACK_TIMEOUT_EN
   logic [3:0] r_cnt;
   logic       r_fault;
   logic       w_timeout;
   assign w_timeout = (r_cnt == 4'(ACK_TIMEOUT - 1));
   assign exc_fault = r_fault;
`else
   assign exc_fault = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_any_exc) w_next = FETCH;
            else if (rte)  w_next = RET;
         end
         FETCH: begin
            if (mem_ack) w_next = LOAD;
`ifdef EXC_ACK_TIMEOUT_EN
            else if (w_timeout) w_next = HALT;
`endif
         end
         LOAD:    w_next = IDLE;
         RET:     w_next = IDLE;
`ifdef EXC_ACK_TIMEOUT_EN
         HALT:    w_next = HALT;
`endif
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      mux_pc_sel = ctrl_pc_sel;
      pc_write   = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (r_state)
         IDLE:  pc_write = ctrl_pc_write;
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = r_vec;
         end
         LOAD: begin
            mux_pc_sel = 3'b001;
            pc_write   = 1'b1;
         end
         RET: begin
            mux_pc_sel = 3'b000;
            pc_write   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_epc     <= '0;
         r_handler <= '0;
         r_vec     <= '0;
         r_cause   <= '0;
         r_busy    <= 1'b0;
`ifdef EXC_ACK_TIMEOUT_EN
         r_cnt     <= '0;
         r_fault   <= 1'b0;
`endif
      end else begin
         r_busy <= (w_next != IDLE);
         if (r_state == IDLE && w_any_exc) begin
            r_epc   <= pc_in - PC_ADJ;
            r_cause <= w_cause;
            r_vec   <= w_vec;
`ifdef EXC_ACK_TIMEOUT_EN
            r_cnt   <= '0;
`endif
         end
         if (r_state == FETCH && mem_ack) r_handler <= {24'b0, mem_rdata[7:0]};
`ifdef EXC_ACK_TIMEOUT_EN
         if (r_state == FETCH && !mem_ack) r_cnt <= r_cnt + 4'd1;
         if (w_next == HALT) r_fault <= 1'b1;
`endif
      end
   end

   assign epc_out      = r_epc;
   assign handler_addr = r_handler;
   assign exc_cause    = r_cause;
   assign exc_busy     = r_busy;

endmodule

// File: tb/tb_exc_pc_sequencer.sv
// Randomized bench for exc_pc_sequencer with a behavioural model checked every negedge,
// plus directed literal checks of the main scenarios.
module tb_exc_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        exc_opcode, exc_ovf, exc_div0, rte;
   logic [2:0]  ctrl_pc_sel;
   logic        ctrl_pc_write;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req;
   logic [31:0] mem_addr, epc_out, handler_addr;
   logic [2:0]  mux_pc_sel;
   logic        pc_write, exc_busy, exc_fault;
   logic [1:0]  exc_cause;

   int n_tests = 0;
   int n_fail  = 0;

   exc_pc_sequencer dut (
      .clk(clk), .reset(reset), .pc_in(pc_in),
      .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0), .rte(rte),
      .ctrl_pc_sel(ctrl_pc_sel), .ctrl_pc_write(ctrl_pc_write),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_addr(mem_addr), .epc_out(epc_out),
      .handler_addr(handler_addr), .mux_pc_sel(mux_pc_sel), .pc_write(pc_write),
      .exc_busy(exc_busy), .exc_cause(exc_cause), .exc_fault(exc_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: what the sequencer is doing ("phase"), and what it has remembered.
   // phase 0 idle, 1 awaiting vector byte, 2 handler load, 3 return, 4 halted
   int          m_phase;
   logic [31:0] m_epc, m_handler, m_vec;
   logic [1:0]  m_cause;
   logic        m_fault;
   int          m_wait;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase = 0; m_epc = 0; m_handler = 0; m_vec = 0;
         m_cause = 0; m_fault = 0; m_wait = 0;
      end else begin
         case (m_phase)
            0: if (exc_opcode || exc_ovf || exc_div0) begin
                  m_epc   = pc_in - 32'd4;
                  m_cause = exc_opcode ? 2'd1 : exc_div0 ? 2'd3 : 2'd2;
                  m_vec   = 32'd252 + 32'(m_cause);
                  m_wait  = 0;
                  m_phase = 1;
               end else if (rte) m_phase = 3;
            1: if (mem_ack) begin
                  m_handler = mem_rdata % 256;
                  m_phase   = 2;
               end else begin
                  m_wait++;
`ifdef EXC_ACK_TIMEOUT_EN
                  if (m_wait == 15) begin
                     m_fault = 1;
                     m_phase = 4;
                  end
`endif
               end
            2, 3: m_phase = 0;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("mux_pc_sel", 32'(mux_pc_sel),
          m_phase == 2 ? 32'd1 : m_phase == 3 ? 32'd0 : 32'(ctrl_pc_sel));
      chk("pc_write", 32'(pc_write),
          m_phase == 0 ? 32'(ctrl_pc_write) : (m_phase == 2 || m_phase == 3) ? 32'd1 : 32'd0);
      chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
      chk("mem_addr", mem_addr, m_phase == 1 ? m_vec : 32'd0);
      chk("exc_busy", 32'(exc_busy), 32'(m_phase != 0));
      chk("epc_out", epc_out, m_epc);
      chk("handler_addr", handler_addr, m_handler);
      chk("exc_cause", 32'(exc_cause), 32'(m_cause));
      chk("exc_fault", 32'(exc_fault), 32'(m_fault));
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req;
      exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; rte = 0;
   endtask

   initial begin
      reset = 0; pc_in = 0; clear_req(); ctrl_pc_sel = 0; ctrl_pc_write = 0;
      mem_rdata = 0; mem_ack = 0;
      tick(); tick();
      chk("rst_epc", epc_out, 32'h0);
      chk("rst_busy", 32'(exc_busy), 32'h0);
      chk("rst_memreq", 32'(mem_req), 32'h0);
      reset = 1;
      ctrl_pc_sel = 3'b010; ctrl_pc_write = 1;
      tick();
      chk("idle_sel", 32'(mux_pc_sel), 32'h2);
      chk("idle_wr", 32'(pc_write), 32'h1);
      chk("idle_busy", 32'(exc_busy), 32'h0);
      chk("idle_epc", epc_out, 32'h0);

      // Overflow, ack after two waiting cycles
      pc_in = 32'h40; exc_ovf = 1;
      tick(); clear_req();
      chk("ovf_addr", mem_addr, 32'd254);
      chk("ovf_req", 32'(mem_req), 32'h1);
      chk("ovf_epc", epc_out, 32'h3C);
      chk("ovf_cause", 32'(exc_cause), 32'h2);
      chk("fetch_wr", 32'(pc_write), 32'h0);
      tick(); tick();
      mem_ack = 1; mem_rdata = 32'hAABBCC7F;
      tick(); mem_ack = 0;
      chk("load_sel", 32'(mux_pc_sel), 32'h1);
      chk("load_wr", 32'(pc_write), 32'h1);
      chk("load_handler", handler_addr, 32'h7F);
      exc_opcode = 1;   // must be ignored in LOAD
      tick(); clear_req();
      chk("ignored_req", 32'(mem_req), 32'h0);
      chk("ignored_cause", 32'(exc_cause), 32'h2);
      rte = 1;
      tick(); clear_req();
      chk("ret_sel", 32'(mux_pc_sel), 32'h0);
      chk("ret_wr", 32'(pc_write), 32'h1);
      chk("ret_epc", epc_out, 32'h3C);
      tick();
      chk("ret_done_busy", 32'(exc_busy), 32'h0);

      // All three causes together
      pc_in = 32'h100; exc_opcode = 1; exc_ovf = 1; exc_div0 = 1;
      tick(); clear_req();
      chk("prio_cause", 32'(exc_cause), 32'h1);
      chk("prio_addr", mem_addr, 32'd253);
      mem_ack = 1; mem_rdata = 32'h12;
      tick(); mem_ack = 0;
      tick();

      // rte with div0 at pc 0: exception wins
      pc_in = 0; rte = 1; exc_div0 = 1;
      tick(); clear_req();
      chk("race_addr", mem_addr, 32'd255);
      chk("race_epc", epc_out, 32'hFFFFFFFC);
      chk("race_wr", 32'(pc_write), 32'h0);
      mem_ack = 1; mem_rdata = 32'h5;
      tick(); mem_ack = 0;
      tick();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         pc_in         = $urandom;
         exc_opcode    = ($urandom_range(0, 11) == 0);
         exc_ovf       = ($urandom_range(0, 9) == 0);
         exc_div0      = ($urandom_range(0, 9) == 0);
         rte           = ($urandom_range(0, 7) == 0);
         ctrl_pc_sel   = 3'($urandom);
         ctrl_pc_write = 1'($urandom);
         mem_rdata     = $urandom;
         mem_ack       = ($urandom_range(0, 2) != 0);
         tick();
      end
      clear_req(); mem_ack = 0;
      reset = 0; tick(); reset = 1; tick();

      // Reset asserted mid-FETCH
      pc_in = 32'h80; exc_ovf = 1;
      tick(); clear_req();
      chk("midrst_pre_req", 32'(mem_req), 32'h1);
      #2 reset = 0;
      #1;
      chk("midrst_req", 32'(mem_req), 32'h0);
      chk("midrst_handler", handler_addr, 32'h0);
      chk("midrst_epc", epc_out, 32'h0);
      tick(); reset = 1; tick();

`ifdef EXC_ACK_TIMEOUT_EN
      ctrl_pc_write = 1; mem_ack = 0; exc_div0 = 1;
      tick(); clear_req();
      for (int i = 0; i < 14; i++) tick();
      chk("to_fault_early", 32'(exc_fault), 32'h0);
      tick();
      chk("to_fault", 32'(exc_fault), 32'h1);
      chk("to_busy", 32'(exc_busy), 32'h1);
      chk("to_wr", 32'(pc_write), 32'h0);
      chk("to_req", 32'(mem_req), 32'h0);
      rte = 1; exc_opcode = 1;
      for (int i = 0; i < 5; i++) tick();
      clear_req();
      chk("halt_fault", 32'(exc_fault), 32'h1);
      chk("halt_wr", 32'(pc_write), 32'h0);
      reset = 0; tick(); reset = 1; tick();
      chk("halt_reset_fault", 32'(exc_fault), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
